// File: rtl/apb_pkg.sv
// Shared types and address-decode helper for the APB master and the
// peripheral interconnect built on the same address map.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DERR   = 2'd3
  } apb_state_t;

  // Default map: four 4 KiB windows. Modules with other parameters derive
  // their own widths from these same formulas.
  localparam int NUM_SLAVES_DEF = 4;
  localparam int SLAVE_SPAN_DEF = 32'h0000_1000;
  localparam int IDX_W          = $clog2(NUM_SLAVES_DEF);
  localparam int SPAN_SH        = $clog2(SLAVE_SPAN_DEF);

  // The decode result always carries a 4-bit index (up to 16 slaves); callers
  // narrow it to their own index width.
  localparam int DEC_IDX_W = 4;

  // Returns {valid, idx}. An address is valid when word aligned, at or above
  // the base, and inside one of the nslv windows.
  function automatic logic [DEC_IDX_W:0] apb_decode(
    input logic [63:0] addr,
    input logic [63:0] base,
    input int unsigned span_sh,
    input int unsigned nslv
  );
    logic [63:0] off;
    logic [63:0] idx_full;
    logic        valid;
    off      = addr - base;
    idx_full = off >> span_sh;
    valid    = (addr[1:0] == 2'b00) && (addr >= base) && (idx_full < 64'(nslv));
    return {valid, idx_full[DEC_IDX_W-1:0]};
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder: byte address -> {valid, slave index,
// one-hot select}. Kept standalone so the interconnect can share it.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int              NUM_SLAVES = 4,
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] SLAVE_SPAN = 32'h0000_1000,
  parameter int              SEL_IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [ADDR_W-1:0]     addr_i,
  output logic                  valid_o,
  output logic [SEL_IDX_W-1:0]  idx_o,
  output logic [NUM_SLAVES-1:0] sel_o
);

  localparam int unsigned SHIFT = $clog2(SLAVE_SPAN);

  logic [DEC_IDX_W:0] dec;

  assign dec     = apb_decode(64'(addr_i), 64'(BASE_ADDR), SHIFT, NUM_SLAVES);
  assign valid_o = dec[DEC_IDX_W];
  assign idx_o   = SEL_IDX_W'(dec[DEC_IDX_W-1:0]);
  assign sel_o   = valid_o ? (NUM_SLAVES'(1) << idx_o) : '0;

endmodule

// File: rtl/apb_master_mux.sv
// APB3 master with multi-slave decode, wait states, PSLVERR propagation,
// decode-error completion and a per-transfer ACCESS timeout.
module apb_master_mux
  import apb_pkg::*;
#(
  parameter int                NUM_SLAVES  = 4,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] SLAVE_SPAN  = 32'h0000_1000,
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         transfer,
  input  logic                         write,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata,
  output logic                         ready,
  output logic                         error,
  output logic [ADDR_W-1:0]            PADDR,
  output logic                         PWRITE,
  output logic [DATA_W-1:0]            PWDATA,
  output logic                         PENABLE,
  output logic [NUM_SLAVES-1:0]        PSEL,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR
);

  localparam int SEL_IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  apb_state_t            state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [SEL_IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  dec_valid;
  logic [SEL_IDX_W-1:0]  dec_idx;
  logic [NUM_SLAVES-1:0] dec_sel;

  logic                  slv_ready;
  logic                  slv_err;
  logic [DATA_W-1:0]     slv_rdata;

  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (BASE_ADDR),
    .SLAVE_SPAN (SLAVE_SPAN),
    .SEL_IDX_W  (SEL_IDX_W)
  ) u_dec (
    .addr_i  (addr),
    .valid_o (dec_valid),
    .idx_o   (dec_idx),
    .sel_o   (dec_sel)
  );

  // The registered index steers the response path of the selected slave.
  assign slv_ready = PREADY[idx_q];
  assign slv_err   = PSLVERR[idx_q];
  assign slv_rdata = PRDATA[32'(idx_q) * DATA_W +: DATA_W];

  // Request fields hold their last value so PADDR/PWDATA stay stable.
  assign PADDR  = addr_q;
  assign PWRITE = write_q;
  assign PWDATA = wdata_q;

  // State and captured-request registers; reset clears everything.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, request capture, bus strobes and completion outputs.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    PSEL    = '0;
    PENABLE = 1'b0;
    ready   = 1'b0;
    error   = 1'b0;
    rdata   = '0;

    case (state_q)
      IDLE: begin
        if (transfer) begin
          addr_d  = addr;
          write_d = write;
          wdata_d = wdata;
          idx_d   = dec_idx;
          sel_d   = dec_sel;
          cnt_d   = '0;
          state_d = dec_valid ? SETUP : DERR;
        end
      end
      SETUP: begin
        PSEL    = sel_q;
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        PSEL    = sel_q;
        PENABLE = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        // A slave response in the last allowed cycle still wins over timeout.
        if (slv_ready) begin
          ready   = 1'b1;
          error   = slv_err;
          rdata   = write_q ? '0 : slv_rdata;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          ready   = 1'b1;
          error   = 1'b1;
          state_d = IDLE;
        end
      end
      DERR: begin
        ready   = 1'b1;
        error   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_master_mux.sv
// Directed self-checking bench for apb_master_mux (default parameters).
module tb_apb_master_mux;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic           PCLK;
  logic           PRESET;
  logic           transfer;
  logic           write;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  wdata;
  logic [DW-1:0]  rdata;
  logic           ready;
  logic           error;
  logic [AW-1:0]  PADDR;
  logic           PWRITE;
  logic [DW-1:0]  PWDATA;
  logic           PENABLE;
  logic [NS-1:0]  PSEL;
  logic [NS*DW-1:0] PRDATA;
  logic [NS-1:0]  PREADY;
  logic [NS-1:0]  PSLVERR;

  int n_tests = 0;
  int n_fail  = 0;

  apb_master_mux dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .transfer (transfer),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .error    (error),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PENABLE  (PENABLE),
    .PSEL     (PSEL),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_prdata(input int k, input logic [DW-1:0] v);
    PRDATA[k*DW +: DW] = v;
  endtask

  task automatic test_reset();
    PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    PRDATA = '0; PREADY = '0; PSLVERR = '0;
    #12;
    n_tests++; if ({PSEL, PENABLE, ready, error, PWRITE} !== 8'b0) begin n_fail++; $display("FAIL reset_ctl: got %b want 00000000", {PSEL, PENABLE, ready, error, PWRITE}); end
    n_tests++; if ({PADDR, PWDATA, rdata} !== 96'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {PADDR, PWDATA, rdata}); end
    PRESET = 1'b0;
    step();
  endtask

  task automatic test_write_zero_wait();
    PREADY = 4'b0001; PSLVERR = 4'b0000;
    transfer = 1'b1; write = 1'b1; addr = 32'h1000_0004; wdata = 32'hDEAD_BEEF;
    #1;
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL wr_idle_ready: got %b want 0", ready); end
    step(); transfer = 1'b0; wdata = 32'h0; #1;
    n_tests++; if ({PSEL, PENABLE, ready, error} !== 7'b0001_0_0_0) begin n_fail++; $display("FAIL wr_setup_ctl: got %b want 0001000", {PSEL, PENABLE, ready, error}); end
    n_tests++; if ({PADDR, PWDATA, PWRITE} !== {32'h1000_0004, 32'hDEAD_BEEF, 1'b1}) begin n_fail++; $display("FAIL wr_setup_bus: got %h %h %b want 10000004 deadbeef 1", PADDR, PWDATA, PWRITE); end
    step();
    n_tests++; if ({PSEL, PENABLE, ready, error} !== 7'b0001_1_1_0) begin n_fail++; $display("FAIL wr_access_ctl: got %b want 0001110", {PSEL, PENABLE, ready, error}); end
    n_tests++; if ({rdata, PWDATA} !== {32'h0, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL wr_access_data: got %h %h want 0 deadbeef", rdata, PWDATA); end
    step();
    n_tests++; if ({PSEL, PENABLE, ready, error} !== 7'b0) begin n_fail++; $display("FAIL wr_done_ctl: got %b want 0000000", {PSEL, PENABLE, ready, error}); end
    n_tests++; if (PADDR !== 32'h1000_0004) begin n_fail++; $display("FAIL wr_paddr_hold: got %h want 10000004", PADDR); end
  endtask

  task automatic test_read_wait();
    set_prdata(0, 32'hAAAA_0000); set_prdata(1, 32'h1111_1111);
    set_prdata(2, 32'h0000_0000); set_prdata(3, 32'h3333_3333);
    PREADY = 4'b1011; PSLVERR = 4'b1011;
    transfer = 1'b1; write = 1'b0; addr = 32'h1000_2010; wdata = 32'h5555_5555;
    step(); transfer = 1'b0; #1;
    n_tests++; if ({PSEL, PENABLE, ready, error} !== 7'b0100_0_0_0) begin n_fail++; $display("FAIL rd_setup_ctl: got %b want 0100000", {PSEL, PENABLE, ready, error}); end
    n_tests++; if ({PADDR, PWRITE} !== {32'h1000_2010, 1'b0}) begin n_fail++; $display("FAIL rd_setup_bus: got %h %b want 10002010 0", PADDR, PWRITE); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if ({PSEL, PENABLE, ready, error, rdata} !== {7'b0100_1_0_0, 32'h0}) begin n_fail++; $display("FAIL rd_wait%0d: got %b %h want 0100100 0", i, {PSEL, PENABLE, ready, error}, rdata); end
    end
    step(); PREADY = 4'b0100; PSLVERR = 4'b1011; set_prdata(2, 32'h1234_5678); #1;
    n_tests++; if ({PSEL, PENABLE, ready, error} !== 7'b0100_1_1_0) begin n_fail++; $display("FAIL rd_done_ctl: got %b want 0100110", {PSEL, PENABLE, ready, error}); end
    n_tests++; if (rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_rdata: got %h want 12345678", rdata); end
    step(); PREADY = 4'b0000; #1;
    n_tests++; if ({PSEL, PENABLE, ready, error, rdata} !== 39'h0) begin n_fail++; $display("FAIL rd_after: got %b %h want 0000000 0", {PSEL, PENABLE, ready, error}, rdata); end
  endtask

  task automatic test_decode_err();
    logic [31:0] bad_addr [4];
    bad_addr[0] = 32'h2000_0000; bad_addr[1] = 32'h1000_0002;
    bad_addr[2] = 32'h1000_4000; bad_addr[3] = 32'h0FFF_FFFC;
    PREADY = 4'b1111; PSLVERR = 4'b0000;
    for (int k = 0; k < NS; k++) set_prdata(k, 32'hF0F0_0000 + 32'(k));
    for (int i = 0; i < 4; i++) begin
      transfer = 1'b1; write = 1'b0; addr = bad_addr[i];
      step(); transfer = 1'b0; #1;
      n_tests++; if ({PSEL, PENABLE, ready, error, rdata} !== {7'b0000_0_1_1, 32'h0}) begin n_fail++; $display("FAIL derr_%h: got %b %h want 0000011 0", bad_addr[i], {PSEL, PENABLE, ready, error}, rdata); end
      step();
      n_tests++; if ({PSEL, PENABLE, ready, error} !== 7'b0) begin n_fail++; $display("FAIL derr_after_%h: got %b want 0000000", bad_addr[i], {PSEL, PENABLE, ready, error}); end
    end
  endtask

  task automatic test_timeout(input logic late_ready);
    logic last;
    PREADY = 4'b0111; PSLVERR = 4'b0000; set_prdata(3, 32'h3C3C_3C3C);
    transfer = 1'b1; write = 1'b0; addr = 32'h1000_3000;
    step(); transfer = 1'b0; #1;
    n_tests++; if ({PSEL, PENABLE, ready, error} !== 7'b1000_0_0_0) begin n_fail++; $display("FAIL to_setup: got %b want 1000000", {PSEL, PENABLE, ready, error}); end
    for (int i = 1; i <= 16; i++) begin
      step();
      last = (i == 16);
      if (last && late_ready) PREADY = 4'b1111;
      #1;
      n_tests++;
      if (late_ready && last) begin
        if ({PSEL, PENABLE, ready, error, rdata} !== {7'b1000_1_1_0, 32'h3C3C_3C3C}) begin n_fail++; $display("FAIL to_priority: got %b %h want 1000110 3c3c3c3c", {PSEL, PENABLE, ready, error}, rdata); end
      end else begin
        if ({PSEL, PENABLE, ready, error, rdata} !== {4'b1000, 1'b1, last, last, 32'h0}) begin n_fail++; $display("FAIL to_cycle%0d: got %b %h want 10001%b%b 0", i, {PSEL, PENABLE, ready, error}, rdata, last, last); end
      end
    end
    step(); PREADY = 4'b0000; #1;
    n_tests++; if ({PSEL, PENABLE, ready, error} !== 7'b0) begin n_fail++; $display("FAIL to_after: got %b want 0000000", {PSEL, PENABLE, ready, error}); end
  endtask

  task automatic test_slverr_ignore();
    PREADY = 4'b0010; PSLVERR = 4'b0010; set_prdata(1, 32'h7777_7777);
    transfer = 1'b1; write = 1'b1; addr = 32'h1000_1000; wdata = 32'h0BAD_F00D;
    step();
    // Second request held high through SETUP and ACCESS must be ignored.
    write = 1'b0; addr = 32'h1000_0000; wdata = 32'h0; #1;
    n_tests++; if ({PSEL, PENABLE, ready, error, PADDR} !== {7'b0010_0_0_0, 32'h1000_1000}) begin n_fail++; $display("FAIL se_setup: got %b %h want 0010000 10001000", {PSEL, PENABLE, ready, error}, PADDR); end
    step();
    n_tests++; if ({PSEL, PENABLE, ready, error} !== 7'b0010_1_1_1) begin n_fail++; $display("FAIL se_access_ctl: got %b want 0010111", {PSEL, PENABLE, ready, error}); end
    n_tests++; if ({PADDR, PWDATA, PWRITE, rdata} !== {32'h1000_1000, 32'h0BAD_F00D, 1'b1, 32'h0}) begin n_fail++; $display("FAIL se_access_bus: got %h %h %b %h want 10001000 0badf00d 1 0", PADDR, PWDATA, PWRITE, rdata); end
    step(); transfer = 1'b0; #1;
    n_tests++; if ({PSEL, PENABLE, ready, error} !== 7'b0) begin n_fail++; $display("FAIL se_idle: got %b want 0000000", {PSEL, PENABLE, ready, error}); end
    step();
    n_tests++; if ({PSEL, PENABLE, ready, error} !== 7'b0) begin n_fail++; $display("FAIL se_no_queue: got %b want 0000000", {PSEL, PENABLE, ready, error}); end
  endtask

  task automatic test_reset_mid();
    PREADY = 4'b0000; PSLVERR = 4'b0000;
    transfer = 1'b1; write = 1'b0; addr = 32'h1000_3004;
    step(); transfer = 1'b0;
    step();
    n_tests++; if ({PSEL, PENABLE, ready, error} !== 7'b1000_1_0_0) begin n_fail++; $display("FAIL rst_pre: got %b want 1000100", {PSEL, PENABLE, ready, error}); end
    PRESET = 1'b1; #1;
    n_tests++; if ({PSEL, PENABLE, ready, error, PWRITE} !== 8'b0) begin n_fail++; $display("FAIL rst_async_ctl: got %b want 00000000", {PSEL, PENABLE, ready, error, PWRITE}); end
    n_tests++; if ({PADDR, PWDATA, rdata} !== 96'h0) begin n_fail++; $display("FAIL rst_async_data: got %h %h %h want 0 0 0", PADDR, PWDATA, rdata); end
    #3 PRESET = 1'b0;
    step();
    n_tests++; if ({PSEL, PENABLE, ready, error} !== 7'b0) begin n_fail++; $display("FAIL rst_no_ready: got %b want 0000000", {PSEL, PENABLE, ready, error}); end
    PREADY = 4'b0001; set_prdata(0, 32'hCAFE_F00D);
    transfer = 1'b1; write = 1'b0; addr = 32'h1000_0008;
    step(); transfer = 1'b0; #1;
    n_tests++; if ({PSEL, PENABLE, ready, error} !== 7'b0001_0_0_0) begin n_fail++; $display("FAIL rst_new_setup: got %b want 0001000", {PSEL, PENABLE, ready, error}); end
    step();
    n_tests++; if ({PSEL, PENABLE, ready, error, rdata} !== {7'b0001_1_1_0, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL rst_new_done: got %b %h want 0001110 cafef00d", {PSEL, PENABLE, ready, error}, rdata); end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_decode_err();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_slverr_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
